stats_reporter: RTL and testbench

Status-report transmitter for the tamagotchi core. It snapshots the five 5-bit pet statistics and the sleep flag, then emits one fixed-format ASCII frame per report over a valid/ready byte stream that feeds the UART transmitter. This is the host-bound counterpart of the stats block's ASCII command input. Reports are triggered periodically from the stats block's `second` toggle, or on demand by the `?` command on the shared command byte bus.

---
 rtl/stats_reporter.sv | 151 +++++++++++++++
 tb/tb_stats_reporter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stats_reporter.sv
// stats_reporter: snapshots the pet statistics and streams one ASCII status frame per report.
//   Frame: "Hdd Pdd Bdd Edd Tdd Z|A\r\n" (23 bytes). With STATS_REPORT_CHECKSUM_EN defined,
//   "*HH" is inserted before CR LF (26 bytes), HH = XOR of every byte from H through Z/A.
//   Ports:
//     clk, reset (sync, active-low)
//     second                      periodic tick source, every level change is one tick
//     hunger..social, is_sleeping live stats, captured at the start of each frame
//     inputs                      command bus, 0x3F requests a report, 0x00 re-arms
//     tx_data/tx_valid/tx_ready   byte stream to the UART transmitter
//     busy                        frame being loaded or sent
//     alarm                       some captured statistic equals 15
module stats_reporter #(
    parameter int unsigned REPORT_EVERY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       second,
    input  logic [4:0] hunger,
    input  logic [4:0] happiness,
    input  logic [4:0] hygiene,
    input  logic [4:0] energy,
    input  logic [4:0] social,
    input  logic       is_sleeping,
    input  logic [7:0] inputs,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       alarm
);
`ifdef STATS_REPORT_CHECKSUM_EN
    localparam logic [4:0] LAST = 5'd25;
`else
    localparam logic [4:0] LAST = 5'd22;
`endif
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
    state_t      state_q;
    logic        second_q, armed_q, pending_q, sleep_q;
    logic [7:0]  tick_q;
    logic [4:0]  idx_q, h_q, p_q, b_q, e_q, t_q;
    logic [4:0]  nidx, v;
    logic [7:0]  lead, tail, nbyte;
    logic        tick, per_trig, cmd_trig, trig, go_again;

    function automatic logic [3:0] tens_of(input logic [4:0] x);
        return x >= 5'd30 ? 4'd3 : x >= 5'd20 ? 4'd2 : x >= 5'd10 ? 4'd1 : 4'd0;
    endfunction

    function automatic logic [7:0] tens_asc(input logic [4:0] x);
        return 8'h30 + {4'b0, tens_of(x)};
    endfunction

    function automatic logic [7:0] ones_asc(input logic [4:0] x);
        return 8'h30 + {3'b0, x} - 8'd10 * {4'b0, tens_of(x)};
    endfunction

`ifdef STATS_REPORT_CHECKSUM_EN
    logic [7:0] csum;

    function automatic logic [7:0] hex_asc(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'b0, n} : 8'h37 + {4'b0, n};
    endfunction

    // Five spaces fold into a single 0x20 term.
    assign csum = 8'h48 ^ 8'h50 ^ 8'h42 ^ 8'h45 ^ 8'h54 ^ 8'h20 ^ (sleep_q ? 8'h5A : 8'h41)
                ^ tens_asc(h_q) ^ ones_asc(h_q) ^ tens_asc(p_q) ^ ones_asc(p_q)
                ^ tens_asc(b_q) ^ ones_asc(b_q) ^ tens_asc(e_q) ^ ones_asc(e_q)
                ^ tens_asc(t_q) ^ ones_asc(t_q);
`endif

    // Next byte to present, chosen from the snapshot by the following index.
    // Bytes 0..19 are four-byte groups: letter, tens, ones, space.
    always_comb begin
        nidx = idx_q + 5'd1;
        v = nidx[4:2] == 3'd0 ? h_q : nidx[4:2] == 3'd1 ? p_q : nidx[4:2] == 3'd2 ? b_q :
            nidx[4:2] == 3'd3 ? e_q : t_q;
        lead = nidx[4:2] == 3'd0 ? 8'h48 : nidx[4:2] == 3'd1 ? 8'h50 : nidx[4:2] == 3'd2 ? 8'h42 :
               nidx[4:2] == 3'd3 ? 8'h45 : 8'h54;
`ifdef STATS_REPORT_CHECKSUM_EN
        tail = nidx == 5'd21 ? 8'h2A : nidx == 5'd22 ? hex_asc(csum[7:4]) :
               nidx == 5'd23 ? hex_asc(csum[3:0]) : nidx == 5'd24 ? 8'h0D : 8'h0A;
`else
        tail = nidx == 5'd21 ? 8'h0D : 8'h0A;
`endif
        nbyte = nidx == 5'd20 ? (sleep_q ? 8'h5A : 8'h41) : nidx > 5'd20 ? tail :
                nidx[1:0] == 2'd0 ? lead : nidx[1:0] == 2'd1 ? tens_asc(v) :
                nidx[1:0] == 2'd2 ? ones_asc(v) : 8'h20;
    end

    assign tick     = second ^ second_q;
    assign per_trig = REPORT_EVERY != 0 && tick && tick_q + 8'd1 == 8'(REPORT_EVERY);
    assign cmd_trig = armed_q && inputs == 8'h3F;
    assign trig     = per_trig || cmd_trig;
    assign go_again = pending_q || trig;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
            alarm     <= 1'b0;
            idx_q     <= 5'd0;
            tick_q    <= 8'd0;
            pending_q <= 1'b0;
            armed_q   <= 1'b1;
            second_q  <= second;
        end else begin
            second_q <= second;
            if (tick && REPORT_EVERY != 0) tick_q <= per_trig ? 8'd0 : tick_q + 8'd1;
            armed_q <= cmd_trig ? 1'b0 : inputs == 8'h00 ? 1'b1 : armed_q;
            case (state_q)
                IDLE: if (trig) begin
                    state_q <= LOAD;
                    busy    <= 1'b1;
                end
                LOAD: begin
                    h_q       <= hunger;
                    p_q       <= happiness;
                    b_q       <= hygiene;
                    e_q       <= energy;
                    t_q       <= social;
                    sleep_q   <= is_sleeping;
                    alarm     <= hunger == 5'd15 || happiness == 5'd15 || hygiene == 5'd15 ||
                                 energy == 5'd15 || social == 5'd15;
                    idx_q     <= 5'd0;
                    pending_q <= go_again;
                    tx_valid  <= 1'b1;
                    tx_data   <= 8'h48;
                    state_q   <= SEND;
                end
                SEND: begin
                    pending_q <= go_again;
                    if (tx_ready) begin
                        if (idx_q == LAST) begin
                            // Entering LOAD consumes the pending request.
                            pending_q <= 1'b0;
                            tx_valid  <= 1'b0;
                            busy      <= go_again;
                            state_q   <= go_again ? LOAD : IDLE;
                        end else begin
                            idx_q   <= nidx;
                            tx_data <= nbyte;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stats_reporter.sv
// tb_stats_reporter: directed checks of frame content, triggers, handshake and reset for stats_reporter.
module tb_stats_reporter;
    logic       clk = 1'b0, reset = 1'b0, second = 1'b0, is_sleeping = 1'b0, tx_ready = 1'b0;
    logic [4:0] hunger = 5'd0, happiness = 5'd0, hygiene = 5'd0, energy = 5'd0, social = 5'd0;
    logic [7:0] inputs = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid, busy, alarm;
    int         errors = 0, checks = 0, flen;
    logic [7:0] rx[$];
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = 8'h00;

    stats_reporter dut (
        .clk(clk), .reset(reset), .second(second), .hunger(hunger), .happiness(happiness),
        .hygiene(hygiene), .energy(energy), .social(social), .is_sleeping(is_sleeping),
        .inputs(inputs), .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .busy(busy), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sink: records accepted bytes and checks that a stalled byte holds.
    always @(posedge clk) begin
        if (reset && pv && !pr) begin
            check("stall_valid", tx_valid, 1);
            check("stall_data", tx_data, pd);
        end
        if (reset && tx_valid && tx_ready) rx.push_back(tx_data);
        pv <= reset && tx_valid;
        pr <= tx_ready;
        pd <= tx_data;
    end

    function automatic string frame_str(input int h, input int p, input int b, input int e,
                                        input int t, input bit z);
        string s;
`ifdef STATS_REPORT_CHECKSUM_EN
        logic [7:0] c;
`endif
        s = $sformatf("H%02d P%02d B%02d E%02d T%02d %s", h, p, b, e, t, z ? "Z" : "A");
`ifdef STATS_REPORT_CHECKSUM_EN
        c = 8'h00;
        for (int i = 0; i < s.len(); i++) c = c ^ s[i];
        s = {s, $sformatf("*%02X", c)};
`endif
        return {s, "\r\n"};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_stats(input logic [4:0] h, input logic [4:0] p, input logic [4:0] b,
                             input logic [4:0] e, input logic [4:0] t, input logic z);
        hunger = h; happiness = p; hygiene = b; energy = e; social = t; is_sleeping = z;
    endtask

    task automatic ask();
        inputs = 8'h3F;
        cyc(1);
        inputs = 8'h00;
    endtask

    task automatic wait_rx(input int n);
        int k = 0;
        while (rx.size() < n && k < 1000) begin
            cyc(1);
            k++;
        end
        if (rx.size() < n) check("rx_timeout", rx.size(), n);
    endtask

    task automatic check_frame(input string tag, input string s);
        check({tag, "_len"}, 32'(rx.size() >= s.len()), 1);
        for (int i = 0; i < s.len() && rx.size() > 0; i++)
            check($sformatf("%s[%0d]", tag, i), rx.pop_front(), s[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        string f;
        logic [15:0] pat;
        flen = frame_str(0, 0, 0, 0, 0, 0).len();
        reset = 1'b0;
        cyc(3);
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_alarm", alarm, 0);
        reset = 1'b1;
        cyc(5);
        check("idle_busy", busy, 0);

        set_stats(7, 3, 12, 5, 1, 0);
        tx_ready = 1'b1;
        second = 1'b1;
        cyc(3);
        check("one_tick_idle", busy, 0);
        second = 1'b0;
        cyc(1);
        check("lat_load_busy", busy, 1);
        check("lat_load_valid", tx_valid, 0);
        cyc(1);
        check("lat_valid", tx_valid, 1);
        check("lat_byte0", tx_data, 8'h48);
        wait_rx(flen);
        cyc(3);
        check_frame("periodic", frame_str(7, 3, 12, 5, 1, 0));
        check("periodic_alarm", alarm, 0);
        check("periodic_extra", rx.size(), 0);
        check("periodic_idle", busy, 0);

        set_stats(19, 8, 0, 11, 2, 1);
        inputs = 8'h3F;
        cyc(50);
        inputs = 8'h00;
        cyc(2);
        inputs = 8'h3F;
        cyc(50);
        inputs = 8'h00;
        cyc(10);
        check("cmd_count", rx.size(), 2 * flen);
        f = frame_str(19, 8, 0, 11, 2, 1);
        check_frame("cmd1", f);
        check_frame("cmd2", f);

        set_stats(15, 4, 4, 4, 4, 0);
        pat = 16'hB2E5;
        ask();
        k = 0;
        while (rx.size() < flen && k < 400) begin
            tx_ready = pat[k[3:0]];
            if (k == 6) hunger = 5'd0;
            cyc(1);
            k++;
        end
        if (rx.size() < flen) check("bp_timeout", rx.size(), flen);
        tx_ready = 1'b1;
        cyc(3);
        check_frame("bp", frame_str(15, 4, 4, 4, 4, 0));
        check("bp_alarm", alarm, 1);

        set_stats(1, 2, 3, 4, 5, 0);
        ask();
        cyc(3);
        ask();
        cyc(2);
        second = 1'b1;
        cyc(2);
        second = 1'b0;
        cyc(2);
        set_stats(6, 7, 8, 9, 10, 0);
        k = 0;
        while (rx.size() < flen && k < 200) begin
            cyc(1);
            k++;
        end
        if (rx.size() < flen) check("pend_timeout", rx.size(), flen);
        check("pend_load_valid", tx_valid, 0);
        check("pend_load_busy", busy, 1);
        cyc(1);
        check("pend_b2b_valid", tx_valid, 1);
        check("pend_b2b_byte0", tx_data, 8'h48);
        wait_rx(2 * flen);
        cyc(40);
        check("pend_count", rx.size(), 2 * flen);
        check_frame("pend1", frame_str(1, 2, 3, 4, 5, 0));
        check_frame("pend2", frame_str(6, 7, 8, 9, 10, 0));
        check("pend_idle", busy, 0);

        set_stats(31, 30, 20, 10, 0, 1);
        ask();
        wait_rx(flen);
        cyc(3);
        check_frame("bound", frame_str(31, 30, 20, 10, 0, 1));
        check("bound_alarm", alarm, 0);

        ask();
        k = 0;
        while (rx.size() < 9 && k < 100) begin
            cyc(1);
            k++;
        end
        check("midrst_progress", rx.size(), 9);
        reset = 1'b0;
        cyc(1);
        check("midrst_valid", tx_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data", tx_data, 0);
        reset = 1'b1;
        cyc(40);
        check("midrst_count", rx.size(), 9);
        check("midrst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
